// File: rtl/ifetch_byte_seq.sv
// ifetch_byte_seq: fetches four ROM bytes per instruction and assembles a 32-bit little-endian word for IF/ID.
// Define IFETCH_MISALIGN_CHK_EN to flag misaligned PCs on inst_err_o instead of fetching them.
module ifetch_byte_seq #(
  parameter logic [31:0] RST_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_i,
  input  logic        jump_flag_i,
  input  logic [1:0]  hold_flag_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic [7:0]  rom_data_i,
  input  logic        rom_ack_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
`ifdef IFETCH_MISALIGN_CHK_EN
  output logic        inst_err_o,
`endif
  output logic        fetch_busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT} state_t;
  state_t      state, state_nxt;
  logic [31:0] base;
  logic [1:0]  byte_cnt;
  logic [23:0] word_q;
  logic        misalign;
  logic        ack;
`ifdef IFETCH_MISALIGN_CHK_EN
  assign misalign = pc_i[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif
  // a jump in the same cycle as an ack discards that byte
  assign ack          = state == S_FETCH && rom_ack_i && !jump_flag_i;
  assign rom_req_o    = state == S_FETCH;
  assign rom_addr_o   = base + {30'b0, byte_cnt};
  assign inst_valid_o = state == S_OUT;
  assign fetch_busy_o = !(state == S_OUT && hold_flag_i == 2'b00);
  always_comb begin
    state_nxt = state;
    if (jump_flag_i) state_nxt = S_IDLE;
    else if (state == S_IDLE) state_nxt = misalign ? S_OUT : S_FETCH;
    else if (ack && byte_cnt == 2'd3) state_nxt = S_OUT;
    else if (state == S_OUT && hold_flag_i == 2'b00) state_nxt = S_IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      base        <= '0;
      byte_cnt    <= '0;
      word_q      <= '0;
      inst_o      <= RST_INST;
      inst_addr_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) base <= pc_i;
      if (state != S_FETCH || jump_flag_i) byte_cnt <= '0;
      else if (ack) byte_cnt <= byte_cnt + 2'd1;
      if (ack) word_q <= {byte_cnt == 2'd2 ? rom_data_i : word_q[23:16],
                          byte_cnt == 2'd1 ? rom_data_i : word_q[15:8],
                          byte_cnt == 2'd0 ? rom_data_i : word_q[7:0]};
      if (ack && byte_cnt == 2'd3) begin
        inst_o      <= {rom_data_i, word_q};
        inst_addr_o <= base;
      end else if (state == S_IDLE && misalign && !jump_flag_i) begin
        inst_o      <= RST_INST;
        inst_addr_o <= pc_i;
      end
    end
  end
`ifdef IFETCH_MISALIGN_CHK_EN
  // entering S_OUT straight from S_IDLE only happens for a misaligned PC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) inst_err_o <= 1'b0;
    else if (state_nxt == S_OUT && state != S_OUT) inst_err_o <= state == S_IDLE;
  end
`endif
endmodule

// File: tb/tb_ifetch_byte_seq.sv
// tb_ifetch_byte_seq: directed bench with a byte ROM responder, PC model and instruction scoreboard.
module tb_ifetch_byte_seq;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc_i;
  logic        jump_flag_i;
  logic [1:0]  hold_flag_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [7:0]  rom_data_i;
  logic        rom_ack_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        fetch_busy_o;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        inst_err_o;
`endif
  logic [31:0] jump_tgt;
  int          rom_wait;
  int          wcnt;
  int          checks = 0;
  int          failures = 0;
  typedef struct {logic [31:0] addr; logic [31:0] word;} exp_t;
  exp_t        sb[$];
  logic [31:0] addr_log[$];
  logic        pend;
  logic [31:0] pend_addr;
  int          n;

  ifetch_byte_seq dut (
    .clk(clk), .rstn(rstn), .pc_i(pc_i), .jump_flag_i(jump_flag_i), .hold_flag_i(hold_flag_i),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .rom_ack_i(rom_ack_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o),
`ifdef IFETCH_MISALIGN_CHK_EN
    .inst_err_o(inst_err_o),
`endif
    .fetch_busy_o(fetch_busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h00100093;
    return (a < 32'd8) ? w[8*a[1:0] +: 8] : a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {rom_byte(a + 32'd3), rom_byte(a + 32'd2), rom_byte(a + 32'd1), rom_byte(a)};
  endfunction

  assign rom_ack_i  = rom_req_o && wcnt == rom_wait;
  assign rom_data_i = rom_byte(rom_addr_o);

  always @(posedge clk or negedge rstn)
    if (!rstn) wcnt <= 0;
    else wcnt <= (rom_req_o && !rom_ack_i) ? wcnt + 1 : 0;

  always @(posedge clk or negedge rstn)
    if (!rstn) pc_i <= '0;
    else if (jump_flag_i) pc_i <= jump_tgt;
    else if (!fetch_busy_o) pc_i <= pc_i + 32'd4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_addr(input logic [31:0] e);
    logic [31:0] a;
    a = 32'hxxxxxxxx;
    if (addr_log.size() != 0) a = addr_log.pop_front();
    chk("rom_addr", a, e);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!inst_valid_o && cnt < 60) begin
      tick();
      cnt++;
    end
  endtask

  // ack log, address-stability check and consume-side scoreboard
  always @(negedge clk) begin
    if (rom_req_o && rom_ack_i) addr_log.push_back(rom_addr_o);
    if (pend && rom_req_o) chk("addr_stable", rom_addr_o, pend_addr);
    pend = rom_req_o && !rom_ack_i;
    pend_addr = rom_addr_o;
    if (rstn && inst_valid_o && hold_flag_i == 2'b00 && !jump_flag_i) begin
      if (sb.size() == 0) chk("sb_empty", inst_o, 32'hxxxxxxxx);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_inst", inst_o, e.word);
        chk("sb_addr", inst_addr_o, e.addr);
      end
    end
  end

  initial begin
    pend = 1'b0;
    rstn = 1'b0;
    hold_flag_i = 2'b01;
    jump_flag_i = 1'b0;
    jump_tgt = '0;
    rom_wait = 0;
    repeat (2) tick();
    chk("rst_req", {31'b0, rom_req_o}, 32'd0);
    chk("rst_addr", rom_addr_o, 32'd0);
    chk("rst_inst", inst_o, 32'h00000013);
    chk("rst_iaddr", inst_addr_o, 32'd0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_busy", {31'b0, fetch_busy_o}, 32'd1);
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("rst_err", {31'b0, inst_err_o}, 32'd0);
`endif
    // zero-wait fetch from 0
    sb.push_back('{32'h0, exp_word(32'h0)});
    rstn = 1'b1;
    wait_valid(n);
    chk("lat_zero_wait", n, 5);
    chk("inst_zero_wait", inst_o, 32'h00100093);
    for (int i = 0; i < 4; i++) chk_addr(32'(i));
    // held in S_OUT
    repeat (3) begin
      chk("hold_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("hold_inst", inst_o, 32'h00100093);
      chk("hold_busy", {31'b0, fetch_busy_o}, 32'd1);
      tick();
    end
    hold_flag_i = 2'b00;
    #1 chk("release_busy", {31'b0, fetch_busy_o}, 32'd0);
    sb.push_back('{32'h4, exp_word(32'h4)});
    tick();
    hold_flag_i = 2'b01;
    chk("busy_after_consume", {31'b0, fetch_busy_o}, 32'd1);
    // two wait cycles per byte
    rom_wait = 2;
    wait_valid(n);
    chk("lat_wait2", n, 13);
    chk("inst_wait2", inst_o, 32'h00100093);
    for (int i = 4; i < 8; i++) chk_addr(32'(i));
    hold_flag_i = 2'b00;
    tick();
    hold_flag_i = 2'b01;
    rom_wait = 0;
    // jump during byte 2 with a same-cycle ack
    repeat (3) tick();
    jump_flag_i = 1'b1;
    jump_tgt = 32'h100;
    tick();
    jump_flag_i = 1'b0;
    chk("jump_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("jump_req", {31'b0, rom_req_o}, 32'd0);
    chk("jump_inst_kept", inst_o, 32'h00100093);
    chk("jump_iaddr_kept", inst_addr_o, 32'h4);
    for (int i = 8; i < 11; i++) chk_addr(32'(i));
    sb.push_back('{32'h100, exp_word(32'h100)});
    wait_valid(n);
    chk("lat_after_jump", n, 5);
    for (int i = 0; i < 4; i++) chk_addr(32'h100 + 32'(i));
    hold_flag_i = 2'b00;
    tick();
    hold_flag_i = 2'b01;
`ifndef IFETCH_MISALIGN_CHK_EN
    // address wrap
    jump_flag_i = 1'b1;
    jump_tgt = 32'hFFFFFFFE;
    tick();
    jump_flag_i = 1'b0;
    sb.push_back('{32'hFFFFFFFE, exp_word(32'hFFFFFFFE)});
    wait_valid(n);
    chk("lat_wrap", n, 5);
    chk_addr(32'hFFFFFFFE);
    chk_addr(32'hFFFFFFFF);
    chk_addr(32'h0);
    chk_addr(32'h1);
`else
    // misaligned PC
    jump_flag_i = 1'b1;
    jump_tgt = 32'h6;
    tick();
    jump_flag_i = 1'b0;
    sb.push_back('{32'h6, 32'h00000013});
    wait_valid(n);
    chk("lat_misalign", n, 1);
    chk("misalign_err", {31'b0, inst_err_o}, 32'd1);
    chk("misalign_inst", inst_o, 32'h00000013);
    chk("misalign_iaddr", inst_addr_o, 32'h6);
    chk("misalign_no_req", addr_log.size(), 0);
`endif
    hold_flag_i = 2'b00;
    tick();
    hold_flag_i = 2'b01;
    // asynchronous reset part-way through a fetch
    repeat (2) tick();
    rstn = 1'b0;
    #1;
    chk("arst_req", {31'b0, rom_req_o}, 32'd0);
    chk("arst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("arst_inst", inst_o, 32'h00000013);
    chk("arst_iaddr", inst_addr_o, 32'd0);
    chk("sb_left", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_byte_seq.md
# ifetch_byte_seq

- Fetch sequencer between the PC register and the IF/ID stage.
- Instructions are stored in byte-wide ROM, four bytes per instruction. The block reads those four bytes from the ROM over a request/acknowledge handshake and assembles a 32-bit little-endian instruction.
- It presents the instruction to IF/ID with a valid flag.
- While a fetch is in progress it asserts a busy flag, which ctrl ORs into the PC hold. A ctrl jump aborts any in-flight fetch.

## Interface
Parameters:
- RST_INST, 32'h00000013, instruction word driven on inst_o at reset (NOP, addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- pc_i  in  32  current PC from pc; byte address of the instruction.
- jump_flag_i  in  1  jump/flush from ctrl; same cycle the PC loads the jump target.
- hold_flag_i  in  2  downstream stall from ctrl, excluding this block's busy; any nonzero value means stall.
- rom_req_o  out  1  ROM byte read request.
- rom_addr_o  out  32  ROM byte address.
- rom_data_i  in  8  ROM read data; valid when rom_ack_i=1.
- rom_ack_i  in  1  ROM acknowledge; may be asserted in the same cycle as the request.
- inst_o  out  32  assembled instruction to if_id.
- inst_addr_o  out  32  PC of inst_o.
- inst_valid_o  out  1  inst_o/inst_addr_o valid.
- fetch_busy_o  out  1  combinational; ctrl holds the PC while it is 1.
- inst_err_o  out  1  misaligned PC flag; present only with IFETCH_MISALIGN_CHK_EN.

## Operation
- Three states: S_IDLE, S_FETCH, S_OUT.
- S_IDLE:
  - Latch base=pc_i and byte_cnt=0.
  - Next state S_FETCH.
- S_FETCH:
  - rom_req_o=1, rom_addr_o=base+byte_cnt. The sum is 32-bit and wraps modulo 2^32.
  - On rom_ack_i=1, store rom_data_i into lane byte_cnt, i.e. bits [8k+7:8k].
  - If byte_cnt==3: load inst_o from the assembled word, load inst_addr_o=base, go to S_OUT. Otherwise byte_cnt+1.
- S_OUT:
  - inst_valid_o=1.
  - If hold_flag_i==0, the instruction is consumed: next state S_IDLE.
  - Otherwise stay in S_OUT with inst_o and inst_addr_o stable.
- fetch_busy_o = ~(state==S_OUT && hold_flag_i==2'b00). The PC therefore advances exactly on the consume edge.
- Jump:
  - jump_flag_i=1 in any state forces S_IDLE on the next edge.
  - The partial word is discarded and byte_cnt is cleared. An ack arriving in the jump cycle is ignored.
  - inst_valid_o is low from the next cycle.
  - Jump takes priority over consume and over ack.
- ROM handshake:
  - rom_addr_o is stable while rom_req_o=1 and no ack has arrived.
  - rom_ack_i is ignored when rom_req_o=0.
  - rom_req_o drops in the cycle after the 4th ack.
- inst_o and inst_addr_o change only on entry to S_OUT. They hold their value otherwise, including after a jump.

## Timing
- Reset values:
  - state=S_IDLE, rom_req_o=0, rom_addr_o=0.
  - inst_o=RST_INST, inst_addr_o=0, inst_valid_o=0.
  - fetch_busy_o=1, inst_err_o=0.
- Zero-wait ROM (ack in the same cycle as req):
  - 1 cycle S_IDLE, 4 cycles S_FETCH, then inst_valid_o rises on the 6th cycle after entering S_IDLE.
  - Minimum issue rate: one instruction per 6 cycles.
- Each ROM wait cycle adds exactly one cycle.
- Reset mid-fetch: all state returns immediately (asynchronously) to the reset values above.

## Configuration
- IFETCH_MISALIGN_CHK_EN defined:
  - In S_IDLE, if pc_i[1:0]!=0, skip S_FETCH and go directly to S_OUT.
  - Drive inst_o=RST_INST, inst_addr_o=pc_i, inst_err_o=1. No ROM request is issued.
  - inst_err_o is cleared on the next entry to S_OUT with an aligned fetch, and on reset.
- IFETCH_MISALIGN_CHK_EN undefined:
  - No inst_err_o port.
  - pc_i is used verbatim and bytes are fetched from pc_i..pc_i+3.

## Test plan
- Zero-wait ROM holding bytes 0x93,0x00,0x10,0x00 at 0x0, release reset -> rom_addr_o 0,1,2,3 on consecutive cycles; inst_o=0x00100093, inst_addr_o=0, inst_valid_o=1 six cycles after reset release.
- ROM ack delayed 2 cycles per byte -> rom_addr_o held constant during waits; valid after 1+12+1 cycles; word identical to the zero-wait case.
- S_OUT with hold_flag_i=2'b01 for 3 cycles -> inst_valid_o stays 1, inst_o stable, fetch_busy_o=1; when hold releases, busy drops for 1 cycle and the next fetch starts at pc_i=0x4.
- jump_flag_i=1 during byte 2 with ack in the same cycle -> byte dropped; next cycle in S_IDLE latches the new pc_i=0x100; the following request is to address 0x100.
- base=0xFFFFFFFE -> rom_addr_o sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- With IFETCH_MISALIGN_CHK_EN, pc_i=0x6 -> no rom_req_o; inst_o=0x00000013, inst_err_o=1, inst_addr_o=0x6, valid on the 2nd cycle.
